axi_lite_mailbox_drainer: RTL and testbench
===========================================

AXI_LITE_MAILBOX_DRAINER -- requirements
Module: axi_lite_mailbox_drainer

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter AxiDataWidth, default 32, AXI-Lite data width.
REQ-003 SHALL have parameter MaxDrain, default 8, maximum words drained per IRQ service, range 1..255.
REQ-004 SHALL have type parameters req_lite_t / resp_lite_t, defaults ariane_axi_soc::req_lite_t / resp_lite_t.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port en_i, input, 1, enables IRQ servicing.
REQ-008 SHALL have port irq_i, input, 1, level mailbox read-threshold interrupt.
REQ-009 SHALL have port base_addr_i, input, AxiAddrWidth, mailbox port base address.
REQ-010 SHALL have port mst_req_o, output, req_lite_t, AXI-Lite master request.
REQ-011 SHALL have port mst_resp_i, input, resp_lite_t, AXI-Lite master response.
REQ-012 SHALL have port data_o, output, AxiDataWidth, drained word.
REQ-013 SHALL have port valid_o, output, 1, data_o valid.
REQ-014 SHALL have port ready_i, input, 1, sink accepts data_o.
REQ-015 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-016 SHALL have port err_o, output, 1, sticky: any non-OKAY R/B response seen.

Function
REQ-017 SHALL use register offsets from base_addr_i: MBOXR 0x04, STATUS 0x08, IRQS 0x18; STATUS[0] = empty.
REQ-018 SHALL implement FSM states IDLE, ST_AR, ST_R, DT_AR, DT_R, PUSH, CLR_AW, CLR_B.
REQ-019 SHALL go IDLE->ST_AR when en_i & irq_i; ar.valid=1, ar.addr=base+0x08 in the next cycle.
REQ-020 SHALL hold ar/aw/w valid and payload stable until the matching ready; never drop valid early.
REQ-021 SHALL keep at most one transaction outstanding; r_ready high only in ST_R/DT_R, b_ready only in CLR_B.
REQ-022 SHALL in ST_R on r handshake: STATUS[0]=1 or drain count == MaxDrain -> CLR_AW; else -> DT_AR.
REQ-023 SHALL in DT_AR issue ar.addr=base+0x04; ST_R/DT_R resolved by same handshake rules.
REQ-024 SHALL in DT_R capture r.data into data_o register, increment 8-bit drain count, go PUSH.
REQ-025 SHALL in PUSH assert valid_o; on valid_o & ready_i go ST_AR (re-read STATUS before every data read).
REQ-026 SHALL keep data_o stable while valid_o & !ready_i; valid_o never high outside PUSH.
REQ-027 SHALL in CLR_AW drive aw.addr=base+0x18, w.data=0x2, w.strb=4'hF, aw/w valid together; each valid drops independently after its own handshake; go CLR_B when both done.
REQ-028 SHALL in CLR_B on b handshake clear drain count and go IDLE.
REQ-029 SHALL on r.resp or b.resp != OKAY set err_o and continue the sequence; a DT_R error still pushes the word (data as returned).
REQ-030 SHALL latch base_addr_i on IDLE exit; changes mid-service ignored.
REQ-031 SHALL ignore en_i deassertion mid-service; service completes to IDLE.
REQ-032 SHALL, if irq_i still high on return to IDLE, restart ST_AR no earlier than one IDLE cycle later.
REQ-033 SHALL drive ar/aw prot=0 and all unused request fields to 0.

Reset
REQ-034 SHALL on rst_i=1 at a clock edge enter IDLE, clear drain count, err_o, data_o; valid_o, busy_o, all AXI valids and readies = 0 the following cycle, including mid-transaction.

Verification
REQ-035 Idle: irq_i=0, en_i=1, 100 cycles -> no AXI valid, busy_o=0.
REQ-036 Drain 3 words 0xA1,0xB2,0xC3, slave STATUS empty after third, ready_i=1 -> data_o sequence A1,B2,C3; 4 STATUS reads, 3 MBOXR reads; one write 0x2 to base+0x18; busy_o low afterwards.
REQ-037 Cap: STATUS never empty, MaxDrain=8 -> exactly 8 pushes, then IRQS write, then IDLE; restart after one cycle while irq_i=1.
REQ-038 Backpressure: ready_i=0 for 20 cycles in PUSH -> data_o stable, no AR issued until accepted.
REQ-039 Slave stalls arready/awready/wready 5 cycles, wready before awready -> payload stable; w.valid drops after its handshake; one B accepted.
REQ-040 Error/reset: SLVERR on STATUS read -> err_o=1 sticky; rst_i mid DT_R -> all valids 0 next cycle, err_o=0.

Source files
------------

// File: rtl/axi_lite_mailbox_drainer.sv
// Services a mailbox read-threshold IRQ over AXI-Lite: polls STATUS, drains MBOXR words
// to a valid/ready sink, then clears the IRQ by writing IRQS. Also holds the default lite types.
package ariane_axi_soc;
  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } aw_chan_lite_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_chan_lite_t;
  typedef struct packed { logic [1:0] resp; } b_chan_lite_t;
  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } ar_chan_lite_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_chan_lite_t;
  typedef struct packed {
    aw_chan_lite_t aw;
    logic          aw_valid;
    w_chan_lite_t  w;
    logic          w_valid;
    logic          b_ready;
    ar_chan_lite_t ar;
    logic          ar_valid;
    logic          r_ready;
  } req_lite_t;
  typedef struct packed {
    logic          aw_ready;
    logic          w_ready;
    b_chan_lite_t  b;
    logic          b_valid;
    logic          ar_ready;
    r_chan_lite_t  r;
    logic          r_valid;
  } resp_lite_t;
endpackage

module axi_lite_mailbox_drainer #(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 32,
  parameter int unsigned MaxDrain     = 8,
  parameter type req_lite_t  = ariane_axi_soc::req_lite_t,
  parameter type resp_lite_t = ariane_axi_soc::resp_lite_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    irq_i,
  input  logic [AxiAddrWidth-1:0] base_addr_i,
  output req_lite_t               mst_req_o,
  input  resp_lite_t              mst_resp_i,
  output logic [AxiDataWidth-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    err_o
);
  // Handshakes: a channel transfers on a rising clk_i edge where its valid and ready
  // are both high; valid and payload are held unchanged until that edge.

  localparam logic [1:0]              RespOkay  = 2'b00;
  localparam logic [7:0]              MaxCnt    = 8'(MaxDrain);
  localparam logic [AxiAddrWidth-1:0] OffMboxr  = AxiAddrWidth'(32'h04);
  localparam logic [AxiAddrWidth-1:0] OffStatus = AxiAddrWidth'(32'h08);
  localparam logic [AxiAddrWidth-1:0] OffIrqs   = AxiAddrWidth'(32'h18);

  typedef enum logic [2:0] {IDLE, ST_AR, ST_R, DT_AR, DT_R, PUSH, CLR_AW, CLR_B} state_e;

  state_e                  state_q;
  logic [AxiAddrWidth-1:0] base_q;
  logic [7:0]              cnt_q;
  logic [AxiDataWidth-1:0] data_q;
  logic                    err_q, valid_q;
  logic                    ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i && irq_i) begin
            base_q     <= base_addr_i;
            ar_valid_q <= 1'b1;
            state_q    <= ST_AR;
          end
        end
        ST_AR, DT_AR: begin
          if (mst_resp_i.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= (state_q == ST_AR) ? ST_R : DT_R;
          end
        end
        ST_R: begin
          if (mst_resp_i.r_valid) begin
            r_ready_q <= 1'b0;
            if (mst_resp_i.r.resp != RespOkay) err_q <= 1'b1;
            // Empty mailbox or drain budget spent: acknowledge the IRQ.
            if (mst_resp_i.r.data[0] || cnt_q == MaxCnt) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= CLR_AW;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= DT_AR;
            end
          end
        end
        DT_R: begin
          if (mst_resp_i.r_valid) begin
            r_ready_q <= 1'b0;
            if (mst_resp_i.r.resp != RespOkay) err_q <= 1'b1;
            data_q  <= mst_resp_i.r.data;
            cnt_q   <= cnt_q + 8'd1;
            valid_q <= 1'b1;
            state_q <= PUSH;
          end
        end
        PUSH: begin
          if (ready_i) begin
            valid_q    <= 1'b0;
            ar_valid_q <= 1'b1;
            state_q    <= ST_AR;
          end
        end
        CLR_AW: begin
          if (mst_resp_i.aw_ready) aw_valid_q <= 1'b0;
          if (mst_resp_i.w_ready)  w_valid_q  <= 1'b0;
          if ((!aw_valid_q || mst_resp_i.aw_ready) && (!w_valid_q || mst_resp_i.w_ready)) begin
            b_ready_q <= 1'b1;
            state_q   <= CLR_B;
          end
        end
        CLR_B: begin
          if (mst_resp_i.b_valid) begin
            b_ready_q <= 1'b0;
            if (mst_resp_i.b.resp != RespOkay) err_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.ar_valid = ar_valid_q;
    mst_req_o.ar.addr  = (state_q == DT_AR) ? base_q + OffMboxr : base_q + OffStatus;
    mst_req_o.r_ready  = r_ready_q;
    mst_req_o.aw_valid = aw_valid_q;
    mst_req_o.aw.addr  = base_q + OffIrqs;
    mst_req_o.w_valid  = w_valid_q;
    mst_req_o.w.data   = AxiDataWidth'(32'h2);
    mst_req_o.w.strb   = '1;
    mst_req_o.b_ready  = b_ready_q;
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != IDLE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_axi_lite_mailbox_drainer.sv
// Bench for axi_lite_mailbox_drainer: a mailbox slave and sink model on the negative edge,
// table-driven service runs plus hand-written reset, cap, backpressure, stall and error sequences.
module tb_axi_lite_mailbox_drainer;
  import ariane_axi_soc::*;

  localparam int MaxDrain = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        irq = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] base_addr = '0;
  req_lite_t   req;
  resp_lite_t  resp = '0;
  logic [31:0] data;
  logic        valid, busy, err;

  axi_lite_mailbox_drainer #(
    .AxiAddrWidth(32), .AxiDataWidth(32), .MaxDrain(MaxDrain),
    .req_lite_t(req_lite_t), .resp_lite_t(resp_lite_t)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .irq_i(irq), .base_addr_i(base_addr),
    .mst_req_o(req), .mst_resp_i(resp), .data_o(data), .valid_o(valid),
    .ready_i(ready), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: mailbox contents and the words the sink must receive, in order.
  logic [31:0] mb_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] svc_base = '0;

  int st_reads = 0, mb_reads = 0, n_writes = 0, n_pushes = 0, stall_cnt = 0;
  int ar_dly = 0, aw_dly = 0, w_dly = 0;
  bit rand_dly = 1'b0, rand_ready = 1'b0, bp_req = 1'b0, err_next_status = 1'b0;
  int bp_cnt = 0;

  // Slave: observes the handshakes of the edge just passed, then drives the next cycle.
  req_lite_t   prev_req = '0;
  logic        prev_rst = 1'b1;
  int          ar_wait = 0, aw_wait = 0, w_wait = 0;
  bit          r_pend = 1'b0, aw_done = 1'b0, w_done = 1'b0, b_pend = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_strb = '0;

  always @(negedge clk) begin : slave
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    if (prev_rst) begin
      resp = '0;
      r_pend = 0; aw_done = 0; w_done = 0; b_pend = 0;
      ar_wait = 0; aw_wait = 0; w_wait = 0;
    end else begin
      ar_hs = prev_req.ar_valid && resp.ar_ready;
      r_hs  = prev_req.r_ready && resp.r_valid;
      aw_hs = prev_req.aw_valid && resp.aw_ready;
      w_hs  = prev_req.w_valid && resp.w_ready;
      b_hs  = prev_req.b_ready && resp.b_valid;
      if (prev_req.ar_valid && !ar_hs)
        check("ar_hold", {req.ar_valid, req.ar.addr}, {1'b1, prev_req.ar.addr});
      if (prev_req.aw_valid && !aw_hs)
        check("aw_hold", {req.aw_valid, req.aw.addr}, {1'b1, prev_req.aw.addr});
      if (prev_req.w_valid && !w_hs)
        check("w_hold", {req.w_valid, req.w.data, req.w.strb},
              {1'b1, prev_req.w.data, prev_req.w.strb});
      if (r_hs) begin r_pend = 0; resp.r_valid = 1'b0; end
      if (b_hs) begin b_pend = 0; resp.b_valid = 1'b0; end
      if (ar_hs) begin
        resp.ar_ready = 1'b0; ar_wait = 0; r_pend = 1; resp.r_valid = 1'b1;
        if (prev_req.ar.addr == svc_base + 32'h8) begin
          st_reads++;
          resp.r.data = {31'd0, (mb_q.size() == 0)};
          resp.r.resp = err_next_status ? 2'b10 : 2'b00;
          err_next_status = 1'b0;
        end else if (prev_req.ar.addr == svc_base + 32'h4) begin
          mb_reads++;
          resp.r.data = (mb_q.size() > 0) ? mb_q.pop_front() : 32'hDEAD_0000;
          resp.r.resp = 2'b00;
        end else begin
          check("ar_addr", prev_req.ar.addr, svc_base + 32'h8);
          resp.r.data = 32'h1;
          resp.r.resp = 2'b11;
        end
      end
      if (aw_hs) begin
        aw_done = 1; wr_addr = prev_req.aw.addr; resp.aw_ready = 1'b0; aw_wait = 0;
        check("aw_drop", req.aw_valid, 1'b0);
      end
      if (w_hs) begin
        w_done = 1; wr_data = prev_req.w.data; wr_strb = prev_req.w.strb;
        resp.w_ready = 1'b0; w_wait = 0;
        check("w_drop", req.w_valid, 1'b0);
      end
      if (aw_done && w_done) begin
        aw_done = 0; w_done = 0; b_pend = 1; n_writes++;
        resp.b_valid = 1'b1; resp.b.resp = 2'b00;
        check("irqs_addr", wr_addr, svc_base + 32'h18);
        check("irqs_data", {wr_strb, wr_data}, {4'hF, 32'h2});
      end
      if (req.ar_valid) check("ar_while_outstanding", {r_pend, b_pend, aw_done, w_done}, 4'b0);
      if (req.aw_valid || req.w_valid) check("wr_while_rd", r_pend, 1'b0);
      if (req.ar_valid && !resp.ar_ready) begin
        if (ar_wait == 0 && rand_dly) ar_dly = $urandom_range(0, 3);
        if (ar_wait >= ar_dly) resp.ar_ready = 1'b1; else ar_wait++;
      end
      if (req.aw_valid && !resp.aw_ready && !aw_done) begin
        if (aw_wait == 0 && rand_dly) aw_dly = $urandom_range(0, 3);
        if (aw_wait >= aw_dly) resp.aw_ready = 1'b1; else aw_wait++;
      end
      if (req.w_valid && !resp.w_ready && !w_done) begin
        if (w_wait == 0 && rand_dly) w_dly = $urandom_range(0, 3);
        if (w_wait >= w_dly) resp.w_ready = 1'b1; else w_wait++;
      end
    end
    prev_req = req;
    prev_rst = rst;
  end

  // Sink scoreboard: each accepted word must be the next expected mailbox word.
  logic        s_prev_valid = 1'b0, s_prev_rst = 1'b1;
  logic [31:0] s_prev_data = '0;

  always @(negedge clk) begin : sink
    if (!s_prev_rst && s_prev_valid) begin
      if (ready) begin
        n_pushes++;
        if (exp_q.size() == 0) check("push_extra", s_prev_data, 64'h1_0000_0000);
        else check("push_data", s_prev_data, exp_q.pop_front());
      end else begin
        stall_cnt++;
        check("data_hold", {valid, data}, {1'b1, s_prev_data});
        check("no_ar_in_push", req.ar_valid, 1'b0);
      end
    end
    if (bp_req && valid && !s_prev_valid) begin bp_cnt = 20; bp_req = 1'b0; end
    if (bp_cnt > 0) begin ready = 1'b0; bp_cnt--; end
    else ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_prev_valid = valid;
    s_prev_data  = data;
    s_prev_rst   = rst;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int n = 0;
    while (busy !== lvl && n < budget) begin tick(); n++; end
    check(lvl ? "busy_rise" : "busy_fall", busy, lvl);
  endtask

  task automatic load_mb(input int n, input int limit);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      mb_q.push_back(w);
      if (i < limit) exp_q.push_back(w);
    end
  endtask

  task automatic clear_counts();
    st_reads = 0; mb_reads = 0; n_writes = 0; n_pushes = 0; stall_cnt = 0;
  endtask

  // One IRQ service with a mid-service base change and en_i drop, which must both be ignored.
  task automatic run_row(input logic [31:0] base, input int e_push, input int e_st, input int e_mb);
    clear_counts();
    svc_base = base; base_addr = base; en = 1'b1; irq = 1'b1;
    wait_busy(1'b1, 50);
    irq = 1'b0; base_addr = ~base; en = 1'b0;
    wait_busy(1'b0, 3000);
    repeat (3) tick();
    check("pushes", n_pushes, e_push);
    check("status_reads", st_reads, e_st);
    check("mboxr_reads", mb_reads, e_mb);
    check("irqs_writes", n_writes, 1);
    check("exp_q_drained", exp_q.size(), 0);
    check("busy_after", busy, 1'b0);
    mb_q.delete();
    en = 1'b1;
  endtask

  typedef struct {
    logic [31:0] base;
    int          n_words;
    int          exp_push;
    int          exp_st;
    int          exp_mb;
  } vec_t;
  vec_t vecs[6];

  int          idle_axi, idle_busy;
  logic [31:0] last_ar;
  bit          found;

  initial begin
    vecs[0] = '{32'h0000_1000,  1, 1, 2, 1};
    vecs[1] = '{32'h0000_2000,  0, 0, 1, 0};
    vecs[2] = '{32'h4000_0100,  5, 5, 6, 5};
    vecs[3] = '{32'h8000_0000,  8, 8, 9, 8};
    vecs[4] = '{32'hFFFF_FF00, 11, 8, 9, 8};
    vecs[5] = '{32'h0001_0040,  7, 7, 8, 7};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid_o", valid, 1'b0);
    check("rst_busy_o", busy, 1'b0);
    check("rst_err_o", err, 1'b0);
    check("rst_data_o", data, 32'h0);
    check("rst_axi", {req.ar_valid, req.r_ready, req.aw_valid, req.w_valid, req.b_ready}, 5'b0);

    en = 1'b1; idle_axi = 0; idle_busy = 0;
    repeat (100) begin
      tick();
      if (req.ar_valid || req.aw_valid || req.w_valid) idle_axi++;
      if (busy) idle_busy++;
    end
    check("idle_axi_valids", idle_axi, 0);
    check("idle_busy", idle_busy, 0);

    mb_q.push_back(32'hA1); mb_q.push_back(32'hB2); mb_q.push_back(32'hC3);
    exp_q.push_back(32'hA1); exp_q.push_back(32'hB2); exp_q.push_back(32'hC3);
    run_row(32'h4000_0000, 3, 4, 3);

    rand_dly = 1'b1; rand_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_mb(vecs[i].n_words, MaxDrain);
      run_row(vecs[i].base, vecs[i].exp_push, vecs[i].exp_st, vecs[i].exp_mb);
    end

    // Cap with irq held: two back-to-back services separated by exactly one IDLE cycle.
    clear_counts();
    load_mb(20, 2 * MaxDrain);
    svc_base = 32'h0000_3000; base_addr = svc_base; irq = 1'b1;
    wait_busy(1'b1, 50);
    wait_busy(1'b0, 3000);
    check("restart_idle_ar", req.ar_valid, 1'b0);
    tick();
    check("restart_busy", busy, 1'b1);
    check("restart_ar", {req.ar_valid, req.ar.addr}, {1'b1, svc_base + 32'h8});
    irq = 1'b0;
    wait_busy(1'b0, 3000);
    repeat (3) tick();
    check("cap_pushes", n_pushes, 2 * MaxDrain);
    check("cap_status_reads", st_reads, 2 * (MaxDrain + 1));
    check("cap_mboxr_reads", mb_reads, 2 * MaxDrain);
    check("cap_writes", n_writes, 2);
    check("cap_exp_q", exp_q.size(), 0);
    mb_q.delete();

    // Sink backpressure for 20 cycles on the first word.
    rand_dly = 1'b0; rand_ready = 1'b0; ar_dly = 0; aw_dly = 0; w_dly = 0;
    load_mb(2, MaxDrain);
    bp_req = 1'b1;
    run_row(32'h0000_5000, 2, 3, 2);
    check("bp_stall_cycles", stall_cnt, 20);

    // Slave stalls, W accepted before AW.
    ar_dly = 5; aw_dly = 5; w_dly = 2;
    load_mb(1, MaxDrain);
    run_row(32'h0000_6000, 1, 2, 1);
    ar_dly = 0; aw_dly = 0; w_dly = 0;

    // SLVERR on STATUS: sticky error, sequence still completes.
    load_mb(2, MaxDrain);
    err_next_status = 1'b1;
    run_row(32'h0000_7000, 2, 3, 2);
    check("err_set", err, 1'b1);
    load_mb(1, MaxDrain);
    run_row(32'h0000_7100, 1, 2, 1);
    check("err_sticky", err, 1'b1);

    // Reset while waiting for an MBOXR read response.
    load_mb(3, MaxDrain);
    svc_base = 32'h0000_8000; base_addr = svc_base; irq = 1'b1;
    last_ar = '0; found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (req.ar_valid) last_ar = req.ar.addr;
      if (req.r_ready && last_ar == svc_base + 32'h4) found = 1'b1;
    end
    check("reach_dt_r", found, 1'b1);
    rst = 1'b1; irq = 1'b0;
    tick();
    check("mid_rst_axi", {req.ar_valid, req.r_ready, req.aw_valid, req.w_valid, req.b_ready}, 5'b0);
    check("mid_rst_valid_o", valid, 1'b0);
    check("mid_rst_busy_o", busy, 1'b0);
    check("mid_rst_err_o", err, 1'b0);
    check("mid_rst_data_o", data, 32'h0);
    rst = 1'b0;
    exp_q.delete(); mb_q.delete();
    repeat (5) tick();
    check("post_rst_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
